bus_read_engine: RTL and testbench
==================================

BUS_READ_ENGINE -- requirements
Module: bus_read_engine

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles mem_rd stays asserted without mem_ack before the read is aborted (legal range 1-255).
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 resetN  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  upstream read request valid.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_addr  input  32  read address; sampled on the req handshake.
REQ-007 mem_rd  output  1  read strobe to the chip bus.
REQ-008 mem_addr  output  32  address presented with mem_rd.
REQ-009 mem_ack  input  1  read data valid from the chip bus.
REQ-010 mem_data  input  64  read data; sampled when mem_ack=1.
REQ-011 rsp_valid  output  1  response valid.
REQ-012 rsp_ready  input  1  downstream accepts the response.
REQ-013 rsp_data  output  64  captured read data.
REQ-014 rsp_parity  output  1  XOR reduction of rsp_data.
REQ-015 rsp_error  output  1  read aborted by timeout.
REQ-016 txn_count  output  16  completed-response counter.
REQ-017 err_count  output  8  timeout counter.

Function
REQ-018 The block SHALL implement a three-state FSM, IDLE -> BUSY -> RESP -> IDLE, with one outstanding read at most.
REQ-019 IDLE: req_ready=1; on req_valid=1, latch req_addr into mem_addr, clear the wait counter, and enter BUSY.
REQ-020 BUSY: mem_rd=1, mem_addr stable, req_ready=0; the wait counter increments each cycle in BUSY.
REQ-021 BUSY with mem_ack=1: capture mem_data into rsp_data, set rsp_parity=^mem_data and rsp_error=0, then enter RESP.
REQ-022 BUSY, wait counter reaching TIMEOUT with mem_ack=0: set rsp_data=0, rsp_parity=0 and rsp_error=1, then enter RESP.
REQ-023 If mem_ack=1 arrives in the same cycle as the timeout, it SHALL win: the read completes normally and no error is flagged.
REQ-024 mem_rd SHALL deassert in the cycle after the mem_ack or timeout cycle.
REQ-025 RESP: rsp_valid=1, and rsp_data, rsp_parity and rsp_error SHALL stay stable until the rsp_valid&&rsp_ready handshake; the block then enters IDLE.
REQ-026 Latency: request accepted in cycle 0, mem_rd=1 from cycle 1; if mem_ack arrives in cycle k, rsp_valid=1 in cycle k+1.
REQ-027 req_ready SHALL be 0 in BUSY and RESP; a new request is accepted no earlier than the cycle after the response handshake.
REQ-028 mem_ack outside BUSY SHALL be ignored, with no state or data change.
REQ-029 txn_count SHALL increment by 1 on each response handshake, error or not, and wrap from 0xFFFF to 0x0000.
REQ-030 err_count SHALL increment on each response handshake with rsp_error=1 and saturate at 0xFF.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 resetN=0 sampled at a rising edge SHALL force state IDLE in the next cycle, in any state including BUSY and RESP.
REQ-033 Reset values: req_ready=1, mem_rd=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_parity=0, rsp_error=0, txn_count=0, err_count=0, wait counter=0.
REQ-034 A read in flight during reset SHALL be dropped with no response, and a later mem_ack SHALL be ignored.

Verification
REQ-035 Normal read: req_addr=0x0000_1000; mem_ack on the 3rd BUSY cycle with mem_data=0x0000_0000_0000_0007 -> rsp_data=0x7, rsp_parity=1, rsp_error=0, txn_count=1.
REQ-036 Timeout: TIMEOUT=15, mem_ack never asserted -> mem_rd high for exactly 15 cycles, then rsp_error=1, rsp_data=0, err_count=1.
REQ-037 Ack on the timeout cycle: mem_ack in BUSY cycle 15 with mem_data=0xFFFF_FFFF_FFFF_FFFF -> rsp_error=0, rsp_parity=0, err_count unchanged.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data held stable, req_ready=0 throughout, and a stray mem_ack is ignored.
REQ-039 Reset mid-read: resetN=0 in BUSY cycle 2 -> mem_rd=0 and req_ready=1 the next cycle, no rsp_valid, counters=0.
REQ-040 Counter wrap: 65536 back-to-back reads -> txn_count returns to 0x0000; 300 timeouts -> err_count=0xFF.

Source files
------------

// File: rtl/bus_read_engine.sv
// Single-outstanding read engine: upstream request -> chip-bus read -> response.
// Aborts a read that waits TIMEOUT cycles for mem_ack and reports it as an error.
module bus_read_engine #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_parity,
  output logic        rsp_error,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // wait_q holds the number of BUSY cycles already spent, so the
  // last permitted BUSY cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  wait_q;
  logic        req_ready_q;
  logic        mem_rd_q;
  logic [31:0] mem_addr_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_data_q;
  logic        rsp_parity_q;
  logic        rsp_error_q;
  logic [15:0] txn_q;
  logic [15:0] txn_d;
  logic [7:0]  err_q;
  logic [7:0]  err_d;
  logic        hs;

  assign hs = rsp_valid_q && rsp_ready;

  always_comb begin
    txn_d = txn_q;
    err_d = err_q;
    if (hs) begin
      txn_d = txn_q + 16'd1;
      if (rsp_error_q && err_q != 8'hFF)
        err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      req_ready_q  <= 1'b1;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_parity_q <= 1'b0;
      rsp_error_q  <= 1'b0;
      txn_q        <= '0;
      err_q        <= '0;
    end else begin
      txn_q <= txn_d;
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr_q  <= req_addr;
            wait_q      <= '0;
            mem_rd_q    <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          wait_q <= wait_q + 8'd1;
          if (mem_ack) begin
            rsp_data_q   <= mem_data;
            rsp_parity_q <= ^mem_data;
            rsp_error_q  <= 1'b0;
            mem_rd_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (wait_q == WaitLast) begin
            rsp_data_q   <= '0;
            rsp_parity_q <= 1'b0;
            rsp_error_q  <= 1'b1;
            mem_rd_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_rd_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_parity = rsp_parity_q;
  assign rsp_error  = rsp_error_q;
  assign txn_count  = txn_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_bus_read_engine.sv
// Directed bench for bus_read_engine: normal read, timeout, ack/timeout race,
// backpressure, stray acks, reset mid-read, back-to-back and err_count saturation.
module tb_bus_read_engine;

  logic        clock;
  logic        resetN;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_parity;
  logic        rsp_error;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  int total;
  int bad;

  bus_read_engine #(.TIMEOUT(15)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_parity (rsp_parity),
    .rsp_error  (rsp_error),
    .txn_count  (txn_count),
    .err_count  (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    step();
    step();
    total++;
    if ({req_ready, mem_rd, rsp_valid, rsp_parity, rsp_error} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 10000",
               {req_ready, mem_rd, rsp_valid, rsp_parity, rsp_error});
    end
    total++;
    if (mem_addr !== 32'h0 || rsp_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h data=%h want 0", mem_addr, rsp_data);
    end
    total++;
    if (txn_count !== 16'h0 || err_count !== 8'h0) begin
      bad++;
      $display("FAIL reset_counts: txn=%h err=%h want 0", txn_count, err_count);
    end
    resetN = 1'b1;
    step();
  endtask

  task automatic test_normal();
    req_addr  = 32'h0000_1000;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    total++;
    if (mem_rd !== 1'b1 || req_ready !== 1'b0 || mem_addr !== 32'h0000_1000) begin
      bad++;
      $display("FAIL normal_busy: rd=%b rdy=%b addr=%h want 1 0 00001000",
               mem_rd, req_ready, mem_addr);
    end
    step();
    step();
    mem_ack  = 1'b1;
    mem_data = 64'h7;
    step();
    mem_ack = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || mem_rd !== 1'b0 || rsp_data !== 64'h7 ||
        rsp_parity !== 1'b1 || rsp_error !== 1'b0) begin
      bad++;
      $display("FAIL normal_rsp: v=%b rd=%b d=%h p=%b e=%b want 1 0 7 1 0",
               rsp_valid, mem_rd, rsp_data, rsp_parity, rsp_error);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++;
    if (txn_count !== 16'd1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL normal_done: txn=%0d rdy=%b v=%b want 1 1 0",
               txn_count, req_ready, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    req_addr  = 32'h0000_2000;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 40 && mem_rd === 1'b1; i++) begin
      hi++;
      step();
    end
    total++;
    if (hi != 15) begin
      bad++;
      $display("FAIL timeout_len: got %0d cycles want 15", hi);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 64'h0 ||
        rsp_parity !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rsp: v=%b e=%b d=%h p=%b want 1 1 0 0",
               rsp_valid, rsp_error, rsp_data, rsp_parity);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++;
    if (err_count !== 8'd1 || txn_count !== 16'd2) begin
      bad++;
      $display("FAIL timeout_cnt: err=%0d txn=%0d want 1 2", err_count, txn_count);
    end
  endtask

  task automatic test_ack_on_timeout();
    req_addr  = 32'h0000_3000;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (14) step();
    total++;
    if (mem_rd !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL race_busy15: rd=%b v=%b want 1 0", mem_rd, rsp_valid);
    end
    mem_ack  = 1'b1;
    mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    mem_ack = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_parity !== 1'b0 ||
        rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL race_rsp: v=%b e=%b p=%b d=%h want 1 0 0 ffffffffffffffff",
               rsp_valid, rsp_error, rsp_parity, rsp_data);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++;
    if (err_count !== 8'd1 || txn_count !== 16'd3) begin
      bad++;
      $display("FAIL race_cnt: err=%0d txn=%0d want 1 3", err_count, txn_count);
    end
  endtask

  task automatic test_backpressure();
    req_addr  = 32'h0000_4000;
    req_valid = 1'b1;
    step();
    mem_ack  = 1'b1;
    mem_data = 64'hDEAD_BEEF_0000_0001;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        mem_ack  = 1'b1;
        mem_data = 64'h1111_2222_3333_4444;
      end else begin
        mem_ack = 1'b0;
      end
      total++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || mem_rd !== 1'b0 ||
          rsp_data !== 64'hDEAD_BEEF_0000_0001 || rsp_parity !== 1'b1 ||
          rsp_error !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: v=%b rdy=%b rd=%b d=%h p=%b e=%b", i,
                 rsp_valid, req_ready, mem_rd, rsp_data, rsp_parity, rsp_error);
      end
      step();
    end
    mem_ack   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++;
    if (txn_count !== 16'd4 || req_ready !== 1'b1 || mem_addr !== 32'h0000_4000) begin
      bad++;
      $display("FAIL bp_done: txn=%0d rdy=%b addr=%h want 4 1 00004000",
               txn_count, req_ready, mem_addr);
    end
  endtask

  task automatic test_idle_ack();
    mem_ack  = 1'b1;
    mem_data = 64'h5555_5555_5555_5555;
    step();
    step();
    mem_ack = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || mem_rd !== 1'b0 || req_ready !== 1'b1 ||
        rsp_data !== 64'hDEAD_BEEF_0000_0001 || txn_count !== 16'd4) begin
      bad++;
      $display("FAIL idle_ack: v=%b rd=%b rdy=%b d=%h txn=%0d", rsp_valid,
               mem_rd, req_ready, rsp_data, txn_count);
    end
  endtask

  task automatic test_back_to_back();
    req_addr  = 32'h0000_5000;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    mem_ack   = 1'b1;
    mem_data  = 64'h0000_0000_0000_0003;
    repeat (30) step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    mem_ack   = 1'b0;
    total++;
    if (txn_count !== 16'd14 || req_ready !== 1'b1 || err_count !== 8'd1) begin
      bad++;
      $display("FAIL b2b_count: txn=%0d rdy=%b err=%0d want 14 1 1",
               txn_count, req_ready, err_count);
    end
    total++;
    if (rsp_data !== 64'h3 || rsp_parity !== 1'b0 || mem_addr !== 32'h0000_5000) begin
      bad++;
      $display("FAIL b2b_data: d=%h p=%b addr=%h want 3 0 00005000",
               rsp_data, rsp_parity, mem_addr);
    end
  endtask

  task automatic test_reset_mid_read();
    req_addr  = 32'h0000_6000;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    total++;
    if (mem_rd !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        txn_count !== 16'd0 || err_count !== 8'd0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid: rd=%b rdy=%b v=%b txn=%0d err=%0d addr=%h",
               mem_rd, req_ready, rsp_valid, txn_count, err_count, mem_addr);
    end
    mem_ack  = 1'b1;
    mem_data = 64'h9;
    step();
    step();
    mem_ack = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || mem_rd !== 1'b0 || rsp_data !== 64'h0) begin
      bad++;
      $display("FAIL rst_late_ack: v=%b rd=%b d=%h want 0 0 0",
               rsp_valid, mem_rd, rsp_data);
    end
  endtask

  task automatic test_err_saturate();
    int stuck;
    stuck = 0;
    for (int n = 0; n < 300; n++) begin
      req_addr  = 32'h0000_7000;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) step();
      if (rsp_valid !== 1'b1) stuck++;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    total++;
    if (stuck != 0) begin
      bad++;
      $display("FAIL sat_timeout_wait: %0d reads never responded want 0", stuck);
    end
    total++;
    if (err_count !== 8'hFF || txn_count !== 16'd300) begin
      bad++;
      $display("FAIL sat_counts: err=%h txn=%0d want ff 300", err_count, txn_count);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    resetN    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_normal();
    test_timeout();
    test_ack_on_timeout();
    test_backpressure();
    test_idle_ack();
    test_back_to_back();
    test_reset_mid_read();
    test_err_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
